// File: rtl/spi_pkg.sv
// Register map, bit positions, FSM encoding and bus-op helpers shared by the
// spi request arbiter and its round-robin picker.
package spi_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_TX     = 2'd2;
  localparam logic [1:0] ADDR_RX     = 2'd3;

  localparam int CTRL_GO_BIT     = 7;
  localparam int STATUS_DONE_BIT = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WCFG,
    ST_WTX,
    ST_GO,
    ST_POLL,
    ST_PWAIT,
    ST_CLR,
    ST_RRX,
    ST_RSP,
    ST_ABORT
  } state_t;

  typedef struct packed {
    logic       en;
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
  } bus_op_t;

  localparam bus_op_t BUS_IDLE = '0;

  function automatic logic [7:0] ctrl_byte(input logic go, input logic [6:0] cfg);
    logic [7:0] b;
    b = {1'b0, cfg};
    b[CTRL_GO_BIT] = go;
    return b;
  endfunction

  function automatic bus_op_t bus_wr(input logic [1:0] addr, input logic [7:0] data);
    bus_op_t op;
    op.en   = 1'b1;
    op.we   = 1'b1;
    op.addr = addr;
    op.data = data;
    return op;
  endfunction

  function automatic bus_op_t bus_rd(input logic [1:0] addr);
    bus_op_t op;
    op.en   = 1'b1;
    op.we   = 1'b0;
    op.addr = addr;
    op.data = 8'h00;
    return op;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// returned both one-hot and as an index.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    index
);

  always_comb begin
    int k;
    k     = 0;
    any   = 1'b0;
    grant = '0;
    index = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        index    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/spi_request_arbiter.sv
// Shares one spi peripheral among N_REQ requesters: round-robin grant, then a
// full register-bus transfer sequence per grant with a bounded status poll.
//
// state    | meaning
// IDLE     | waiting for a request; grant and latch on the same edge
// WCFG     | write CTRL with go clear
// WTX      | write TX byte
// GO       | write CTRL with go set, arm poll timer
// POLL     | read STATUS
// PWAIT    | sample STATUS: done, timeout or poll again
// CLR      | write CTRL with go clear
// RRX      | read RX
// RSP      | sample RX byte, respond
// ABORT    | write CTRL with go clear, respond with error
module spi_request_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [7*N_REQ-1:0] req_cfg,
  input  logic [8*N_REQ-1:0] req_tx,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               spi_enable,
  output logic               spi_write_en,
  output logic [1:0]         spi_address,
  output logic [7:0]         spi_write_data,
  input  logic [7:0]         spi_read_data
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state;
  bus_op_t          bus;
  logic [IW-1:0]    ptr;
  logic [N_REQ-1:0] owner;
  logic [6:0]       cfg_q;
  logic [7:0]       tx_q;
  logic [CW-1:0]    poll_cnt;

  logic             arb_any;
  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_index;
  logic [6:0]       cfg_sel;
  logic [7:0]       tx_sel;

  spi_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .any   (arb_any),
    .grant (arb_grant),
    .index (arb_index)
  );

  assign cfg_sel = req_cfg[7*int'(arb_index) +: 7];
  assign tx_sel  = req_tx[8*int'(arb_index) +: 8];

  assign spi_enable     = bus.en;
  assign spi_write_en   = bus.we;
  assign spi_address    = bus.addr;
  assign spi_write_data = bus.data;

  // Bus op registers are loaded on entry to a state so the strobe is visible
  // during that state; the read byte is therefore valid in the following state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bus       <= BUS_IDLE;
      ptr       <= '0;
      owner     <= '0;
      cfg_q     <= '0;
      tx_q      <= '0;
      poll_cnt  <= '0;
      grant     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bus       <= BUS_IDLE;
      grant     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant <= arb_grant;
            owner <= arb_grant;
            cfg_q <= cfg_sel;
            tx_q  <= tx_sel;
            ptr   <= (arb_index == IW'(N_REQ - 1)) ? '0 : arb_index + 1'b1;
            busy  <= 1'b1;
            bus   <= bus_wr(ADDR_CTRL, ctrl_byte(1'b0, cfg_sel));
            state <= ST_WCFG;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_WCFG: begin
          bus   <= bus_wr(ADDR_TX, tx_q);
          state <= ST_WTX;
        end
        ST_WTX: begin
          bus   <= bus_wr(ADDR_CTRL, ctrl_byte(1'b1, cfg_q));
          state <= ST_GO;
        end
        ST_GO: begin
          poll_cnt <= CW'(TIMEOUT);
          bus      <= bus_rd(ADDR_STATUS);
          state    <= ST_POLL;
        end
        ST_POLL: begin
          state <= ST_PWAIT;
        end
        ST_PWAIT: begin
          // Done wins over timeout, so a done seen on the last allowed poll still succeeds.
          if (spi_read_data[STATUS_DONE_BIT]) begin
            bus   <= bus_wr(ADDR_CTRL, ctrl_byte(1'b0, cfg_q));
            state <= ST_CLR;
          end else if (poll_cnt == '0) begin
            bus   <= bus_wr(ADDR_CTRL, ctrl_byte(1'b0, cfg_q));
            state <= ST_ABORT;
          end else begin
            poll_cnt <= poll_cnt - 1'b1;
            bus      <= bus_rd(ADDR_STATUS);
            state    <= ST_POLL;
          end
        end
        ST_CLR: begin
          bus   <= bus_rd(ADDR_RX);
          state <= ST_RRX;
        end
        ST_RRX: begin
          state <= ST_RSP;
        end
        ST_RSP: begin
          rsp_valid <= owner;
          rsp_data  <= spi_read_data;
          state     <= ST_IDLE;
        end
        ST_ABORT: begin
          rsp_valid <= owner;
          rsp_err   <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
